switch_conditioner: RTL and testbench

Front-end input stage for the switch-programmed CPU. It takes the raw, asynchronous toggle switches and eight binary data switches. It synchronises and debounces them, then presents clean single-cycle command pulses (execute, insert, forward) and a stable 8-bit data byte to the CPU FSM. The CPU consumes `exec_pulse`, `insert_pulse` and `fwd_pulse` directly in its idle and input states, and reads `b_stable` as its binary input.

---
 rtl/swcond_pkg.sv | 19 +
 rtl/debounce_ch.sv | 108 ++++++++++
 rtl/switch_conditioner.sv | 134 +++++++++++++
 tb/tb_switch_conditioner.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/swcond_pkg.sv
// Shared types and constants for the switch conditioner front end.
// Channel FSM states, channel indices and the default debounce length.
package swcond_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RISE,
    PRESSED,
    FALL
  } ch_state_t;

  localparam int CH_EXEC   = 0;
  localparam int CH_INSERT = 1;
  localparam int CH_FWD    = 2;
  localparam int NUM_CH    = 3;

  localparam int DEBOUNCE_DEFAULT = 250000;

endpackage

// File: rtl/debounce_ch.sv
// One toggle channel: 2-FF synchroniser, debounce FSM and counter.
// Raises press_req for one cycle when a press is accepted.
module debounce_ch
  import swcond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_req,
  output logic pressed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic          din;
  ch_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          level_q, level_d;
  logic          req_q, req_d;
  logic          done;

  assign din       = sync_q[1];
  assign level     = level_q;
  assign press_req = req_q;
  assign pressed   = (state_q == PRESSED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      req_q   <= req_d;
    end
  end

  // Counter saturates rather than wrapping
  assign cnt_inc = (cnt_q == CNT_MAX) ?
                   cnt_q : cnt_q + CW'(1);
  assign done    = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    req_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (din) begin
          state_d = RISE;
          cnt_d   = '0;
        end
      end
      RISE: begin
        if (!din) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (done) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          req_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (!din) begin
          state_d = FALL;
          cnt_d   = '0;
        end
      end
      FALL: begin
        if (din) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (done) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/switch_conditioner.sv
// Switch front end: debounced toggles, arbitrated pulses, data byte.
// Define SWCOND_AUTOREPEAT_EN to build forward auto-repeat.
module switch_conditioner
  import swcond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s2,
  input  logic       s3,
  input  logic       s4,
  input  logic [7:0] b_raw,
  output logic       exec_pulse,
  output logic       insert_pulse,
  output logic       fwd_pulse,
  output logic       exec_level,
  output logic       insert_level,
  output logic       fwd_level,
  output logic [7:0] b_stable,
  output logic       b_changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES);

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] lvl;
  logic [NUM_CH-1:0] pressed;
  logic              fwd_req;
  logic              unused_pressed;

  assign raw = {s4, s3, s2};
  assign unused_pressed = ^pressed;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (raw[i]),
      .level    (lvl[i]),
      .press_req(req[i]),
      .pressed  (pressed[i])
    );
  end

  assign exec_level   = lvl[CH_EXEC];
  assign insert_level = lvl[CH_INSERT];
  assign fwd_level    = lvl[CH_FWD];

`ifdef SWCOND_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_armed;
  logic          rep_req;

  // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
      rep_req   <= 1'b0;
    end else if (!pressed[CH_FWD]) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
      rep_req   <= 1'b0;
    end else if (!rep_armed &&
                 rep_cnt == RW'(REPEAT_DELAY - 1)) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b1;
      rep_req   <= 1'b1;
    end else if (rep_armed &&
                 rep_cnt == RW'(REPEAT_PERIOD - 1)) begin
      rep_cnt <= '0;
      rep_req <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
      rep_req <= 1'b0;
    end
  end

  assign fwd_req = req[CH_FWD] | rep_req;
`else
  assign fwd_req = req[CH_FWD];
`endif

  // exec > insert > fwd; losers are dropped
  assign exec_pulse   = req[CH_EXEC];
  assign insert_pulse = req[CH_INSERT] & ~req[CH_EXEC];
  assign fwd_pulse    = fwd_req & ~req[CH_EXEC] &
                        ~req[CH_INSERT];

  logic [7:0]    b_sync1, b_sync, b_prev;
  logic [CW-1:0] b_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_sync1   <= '0;
      b_sync    <= '0;
      b_prev    <= '0;
      b_cnt     <= '0;
      b_stable  <= '0;
      b_changed <= 1'b0;
    end else begin
      b_sync1   <= b_raw;
      b_sync    <= b_sync1;
      b_prev    <= b_sync;
      b_changed <= 1'b0;
      if (b_sync != b_prev) begin
        b_cnt <= '0;
      end else if (b_cnt == CNT_LAST) begin
        b_cnt <= CNT_MAX;
        if (b_sync != b_stable) begin
          b_stable  <= b_sync;
          b_changed <= 1'b1;
        end
      end else if (b_cnt != CNT_MAX) begin
        b_cnt <= b_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner, DEBOUNCE_CYCLES = 4.
// Covers repeat behaviour when SWCOND_AUTOREPEAT_EN is defined.
module tb_switch_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s2, s3, s4;
  logic [7:0] b_raw;
  logic       exec_pulse, insert_pulse, fwd_pulse;
  logic       exec_level, insert_level, fwd_level;
  logic [7:0] b_stable;
  logic       b_changed;

  int checks = 0;
  int errors = 0;

`ifdef SWCOND_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  switch_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s2          (s2),
    .s3          (s3),
    .s4          (s4),
    .b_raw       (b_raw),
    .exec_pulse  (exec_pulse),
    .insert_pulse(insert_pulse),
    .fwd_pulse   (fwd_pulse),
    .exec_level  (exec_level),
    .insert_level(insert_level),
    .fwd_level   (fwd_level),
    .b_stable    (b_stable),
    .b_changed   (b_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulses"},
          {exec_pulse, insert_pulse, fwd_pulse}, 0);
    check({tag, "_levels"},
          {exec_level, insert_level, fwd_level}, 0);
    check({tag, "_b_stable"}, b_stable, 8'h00);
    check({tag, "_b_changed"}, b_changed, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    s2 = 0; s3 = 0; s4 = 0;
    b_raw = 8'h00;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("idle_b_changed", b_changed, 0);
    end

    // exec press: pulse at edge 6 only
    s2 = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1_exec_pulse", exec_pulse, (i == 6));
      check("t1_exec_level", exec_level, (i >= 6));
      check("t1_others", {insert_pulse, fwd_pulse}, 0);
    end
    s2 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1_rel_level", exec_level, (i < 6));
      check("t1_rel_pulse", exec_pulse, 0);
    end

    // 3-sample glitch is rejected
    s2 = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 2) s2 = 0;
      check("glitch_pulse", exec_pulse, 0);
      check("glitch_level", exec_level, 0);
    end

    // insert bounce 1,1,0,1,1,...
    for (int i = 0; i < 13; i++) begin
      s3 = (i == 2) ? 1'b0 : 1'b1;
      tick();
      check("t2_ins_pulse", insert_pulse, (i == 9));
      check("t2_ins_level", insert_level, (i >= 9));
    end
    s3 = 0;
    repeat (10) tick();
    check("t2_rel_level", insert_level, 0);

    // exec and fwd together: exec wins
    s2 = 1; s4 = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_exec_pulse", exec_pulse, (i == 6));
      check("t3_fwd_pulse", fwd_pulse, 0);
    end
    check("t3_levels", {exec_level, fwd_level}, 2'b11);
    s2 = 0; s4 = 0;
    repeat (10) tick();
    check("t3_rel_levels", {exec_level, fwd_level}, 0);

    // data byte A5 then 3C
    b_raw = 8'hA5;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i == 1) b_raw = 8'h3C;
      check("t4_b_changed", b_changed, (i == 8));
      check("t4_b_stable", b_stable,
            (i >= 8) ? 8'h3C : 8'h00);
    end

    // brief data glitch, same settled value
    b_raw = 8'h00;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 1) b_raw = 8'h3C;
      check("t4g_b_changed", b_changed, 0);
      check("t4g_b_stable", b_stable, 8'h3C);
    end

    // reset mid-RISE, then re-press from scratch
    s2 = 1;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    tick();
    tick();
    check_all_zero("t5_held");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_exec_pulse", exec_pulse, (i == 6));
      check("t5_b_changed", b_changed, (i == 6));
      check("t5_b_stable", b_stable,
            (i >= 6) ? 8'h3C : 8'h00);
    end
    s2 = 0;
    repeat (10) tick();

    // forward hold: repeats only with the macro
    s4 = 1;
    for (int i = 0; i < 76; i++) begin
      tick();
      if (i == 62) s4 = 0;
      if (AR)
        check("t6_fwd_pulse", fwd_pulse,
              (i inside {6, 26, 34, 42, 50, 58}));
      else
        check("t6_fwd_pulse", fwd_pulse, (i == 6));
    end
    check("t6_rel_level", fwd_level, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
